// File: rtl/sw_debounce_pkg.sv
// Board-level constants and shared types for the slide-switch debouncer.
// The per-channel FSM state type is shared so the top can decode channel idleness.
package sw_debounce_pkg;

    localparam int CLK_FREQ_HZ             = 100_000_000;
    localparam int DEBOUNCE_MS             = 10;
    localparam int DEBOUNCE_CYCLES_DEFAULT = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;
    localparam int SIM_DEBOUNCE_CYCLES     = 4;

    typedef enum logic {
        DB_IDLE  = 1'b0,
        DB_COUNT = 1'b1
    } db_state_t;

    function automatic int cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch channel: synchronizer chain, stability counter, two-state FSM and change pulse.
// The debounced level only moves after the synchronized input differs for DEBOUNCE_CYCLES edges.
module debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      raw,
    output logic      level,
    output logic      changed,
    output logic      sync,
    output db_state_t state
);

    localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    db_state_t              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   changed_q, changed_d;

    // Plain shift chain: nothing may sit between these flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= DB_IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            changed_q <= changed_d;
        end
    end

    // The IDLE edge that first sees a difference already counts as cycle one.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        changed_d = 1'b0;
        case (state_q)
            DB_IDLE: begin
                cnt_d = '0;
                if (sync != level_q) begin
                    state_d = DB_COUNT;
                    cnt_d   = CNT_ONE;
                end
            end
            DB_COUNT: begin
                if (sync == level_q) begin
                    state_d = DB_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = DB_IDLE;
                    cnt_d     = '0;
                    level_d   = sync;
                    changed_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = DB_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign level   = level_q;
    assign changed = changed_q;
    assign state   = state_q;

endmodule

// File: rtl/sw_debounce.sv
// Slide-switch bus debouncer feeding lab1: WIDTH independent channels plus a global STABLE flag.
// SW and SW_CHANGED come straight from channel flops; STABLE decodes registered channel state.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             CLK100MHZ,
    input  logic             CPU_RESETN,
    input  logic [WIDTH-1:0] SW_RAW,
    output logic [WIDTH-1:0] SW,
    output logic [WIDTH-1:0] SW_CHANGED,
    output logic             STABLE
);

    logic [WIDTH-1:0] sync_bits;
    logic [WIDTH-1:0] idle_bits;
    db_state_t        bit_state [WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk    (CLK100MHZ),
            .rst_n  (CPU_RESETN),
            .raw    (SW_RAW[i]),
            .level  (SW[i]),
            .changed(SW_CHANGED[i]),
            .sync   (sync_bits[i]),
            .state  (bit_state[i])
        );

        assign idle_bits[i] = (bit_state[i] == DB_IDLE) && (sync_bits[i] == SW[i]);
    end

    assign STABLE = &idle_bits;

endmodule
